// File: rtl/axi_stream_extract_header_pkg.sv
// Shared definitions for the header-extraction datapath.
// - FSM state encodings (IDLE / BODY / FLUSH)
// - keep2cnt  : leading-ones count of an MSB-aligned keep field
// - cnt2keep  : byte count -> MSB-aligned keep field
// - clamp_cnt : maps an out-of-range header length (0 or > W) to W
// Keep fields are passed zero-extended to MAX_BYTES bits. The meaningful
// field occupies the low w bits, with its MSB at bit w-1.
package axis_hdr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int MAX_BYTES = 64;
    typedef logic [MAX_BYTES-1:0] bmask_t;

    // Count ones from the MSB of a w-bit field, stopping at the first zero.
    // Holes in a malformed keep therefore truncate the count; they never
    // produce a count larger than w.
    function automatic int keep2cnt(input bmask_t keep, input int w);
        bmask_t k;
        logic   run;
        int     cnt;
        k   = keep << (MAX_BYTES - w);
        run = 1'b1;
        cnt = 0;
        for (int i = MAX_BYTES - 1; i >= 0; i--) begin
            if (run && k[i]) cnt++;
            else             run = 1'b0;
        end
        return cnt;
    endfunction

    // cnt ones at the top of a w-bit field.
    function automatic bmask_t cnt2keep(input int cnt, input int w);
        bmask_t m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            m[i] = (i < w) && (i >= w - cnt);
        return m;
    endfunction

    function automatic int clamp_cnt(input int n, input int w);
        return (n == 0 || n > w) ? w : n;
    endfunction

endpackage

// File: rtl/axi_stream_extract_header_if.sv
// Bundle of the input stream, payload output stream, header port and
// error pulse of axi_stream_extract_header.
// - master : environment side (drives input beats, output/header readies, N)
// - slave  : extractor side
interface axi_stream_extract_header_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) ();
    // input stream
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;
    // payload stream
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;
    // header port
    logic [BYTE_CNT_WD:0]    byte_extract_cnt;
    logic                    valid_header;
    logic [DATA_WD-1:0]      data_header;
    logic [DATA_BYTE_WD-1:0] keep_header;
    logic                    ready_header;
    logic                    err_short;

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
               byte_extract_cnt, ready_header,
        input  ready_in, valid_out, data_out, keep_out, last_out,
               valid_header, data_header, keep_header, err_short
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
               byte_extract_cnt, ready_header,
        output ready_in, valid_out, data_out, keep_out, last_out,
               valid_header, data_header, keep_header, err_short
    );
endinterface

// File: rtl/axi_stream_extract_header_realign.sv
// axis_byte_realign: combinational join of a residual and a new beat.
// Ports:
//   res_data_i / res_cnt_i   : residual bytes (MSB-aligned, bytes past
//                              res_cnt_i are zero) and their count
//   beat_data_i / beat_cnt_i : incoming beat and its valid-byte count
//   out_data_o / out_keep_o  : first W bytes of the joined stream
//   res_data_o / res_cnt_o   : bytes past W, MSB-aligned, and their count
module axis_byte_realign
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]      res_data_i,
    input  logic [BYTE_CNT_WD:0]    res_cnt_i,
    input  logic [DATA_WD-1:0]      beat_data_i,
    input  logic [BYTE_CNT_WD:0]    beat_cnt_i,
    output logic [DATA_WD-1:0]      out_data_o,
    output logic [DATA_BYTE_WD-1:0] out_keep_o,
    output logic [DATA_WD-1:0]      res_data_o,
    output logic [BYTE_CNT_WD:0]    res_cnt_o
);
    localparam int W     = DATA_BYTE_WD;
    localparam int CNT_W = BYTE_CNT_WD + 1;

    logic [W-1:0]         beat_keep;
    logic [DATA_WD-1:0]   beat_mask;
    logic [DATA_WD-1:0]   beat_clean;
    logic [2*DATA_WD-1:0] joined;
    int                   sum;

    always_comb begin
        beat_keep = W'(cnt2keep(int'(beat_cnt_i), W));
        beat_mask = '0;
        for (int b = 0; b < W; b++)
            beat_mask[b*8 +: 8] = {8{beat_keep[b]}};
        // Bytes beyond the beat's count are cleared so they cannot leak into
        // the residual that is carried into the next beat.
        beat_clean = beat_data_i & beat_mask;
        // 2W-byte window: residual at the top, beat appended right after it.
        joined = {res_data_i, {DATA_WD{1'b0}}}
               | ({beat_clean, {DATA_WD{1'b0}}} >> (8 * int'(res_cnt_i)));
        sum = int'(res_cnt_i) + int'(beat_cnt_i);

        out_data_o = joined[2*DATA_WD-1 -: DATA_WD];
        if (sum >= W) begin
            out_keep_o = '1;
            res_data_o = joined[DATA_WD-1:0];
            res_cnt_o  = CNT_W'(sum - W);
        end else begin
            out_keep_o = W'(cnt2keep(sum, W));
            res_data_o = '0;
            res_cnt_o  = '0;
        end
    end
endmodule

// File: rtl/axi_stream_extract_header.sv
// axi_stream_extract_header: strips the first N bytes of each packet onto a
// header port and re-aligns the rest of the packet MSB-first onto the
// payload port. A flush beat is emitted when bytes remain after the last
// input beat.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of axi_stream_extract_header_if (input stream,
//                payload stream, header port, byte_extract_cnt, err_short)
module axi_stream_extract_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                        clk,
    input logic                        rst_n,
    axi_stream_extract_header_if.slave bus
);
    localparam int W     = DATA_BYTE_WD;
    localparam int DW    = DATA_WD;
    localparam int CNT_W = BYTE_CNT_WD + 1;

    logic [1:0]       state_q, state_d;
    logic             hdr_vld_q, hdr_vld_d;
    logic [DW-1:0]    hdr_data_q, hdr_data_d;
    logic [W-1:0]     hdr_keep_q, hdr_keep_d;
    logic [DW-1:0]    res_data_q, res_data_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [W-1:0]     out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic             err_q, err_d;

    // First-beat split. N only matters at the first-beat accept: after that
    // it is carried implicitly by the residual it leaves behind.
    int               n_now, k_now, hdr_n, res_n;
    logic [CNT_W-1:0] k_cnt;
    logic [W-1:0]     in_keep, hdr_keep, flush_keep;
    logic [DW-1:0]    in_mask, hdr_mask, in_clean;

    always_comb begin
        n_now      = clamp_cnt(int'(bus.byte_extract_cnt), W);
        k_now      = keep2cnt(bmask_t'(bus.keep_in), W);
        k_cnt      = CNT_W'(k_now);
        hdr_n      = (k_now < n_now) ? k_now : n_now;
        res_n      = (k_now > n_now) ? k_now - n_now : 0;
        in_keep    = W'(cnt2keep(k_now, W));
        hdr_keep   = W'(cnt2keep(hdr_n, W));
        flush_keep = W'(cnt2keep(int'(res_cnt_q), W));
        in_mask    = '0;
        hdr_mask   = '0;
        for (int b = 0; b < W; b++) begin
            in_mask[b*8 +: 8]  = {8{in_keep[b]}};
            hdr_mask[b*8 +: 8] = {8{hdr_keep[b]}};
        end
        in_clean = bus.data_in & in_mask;
    end

    logic [DW-1:0]    ra_data, ra_res_data;
    logic [W-1:0]     ra_keep;
    logic [CNT_W-1:0] ra_res_cnt;

    axis_byte_realign #(
        .DATA_WD     (DATA_WD),
        .DATA_BYTE_WD(DATA_BYTE_WD),
        .BYTE_CNT_WD (BYTE_CNT_WD)
    ) u_realign (
        .res_data_i (res_data_q),
        .res_cnt_i  (res_cnt_q),
        .beat_data_i(bus.data_in),
        .beat_cnt_i (k_cnt),
        .out_data_o (ra_data),
        .out_keep_o (ra_keep),
        .res_data_o (ra_res_data),
        .res_cnt_o  (ra_res_cnt)
    );

    // The payload register can take a new beat when it is empty or being
    // drained this cycle.
    logic out_free, ready_in, accept;

    always_comb begin
        out_free = !out_vld_q || bus.ready_out;
        case (state_q)
            ST_IDLE: ready_in = !hdr_vld_q;
            ST_BODY: ready_in = out_free;
            default: ready_in = 1'b0;
        endcase
        accept = bus.valid_in && ready_in;
    end

    always_comb begin
        state_d    = state_q;
        hdr_vld_d  = hdr_vld_q;
        hdr_data_d = hdr_data_q;
        hdr_keep_d = hdr_keep_q;
        res_data_d = res_data_q;
        res_cnt_d  = res_cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        err_d      = 1'b0;

        if (bus.ready_header) hdr_vld_d = 1'b0;
        if (bus.ready_out)    out_vld_d = 1'b0;

        case (state_q)
            ST_IDLE: if (accept) begin
                hdr_vld_d  = 1'b1;
                hdr_data_d = bus.data_in & hdr_mask;
                hdr_keep_d = hdr_keep;
                // Shift by N (not by the header bytes actually present):
                // on a short beat this empties the residual.
                res_data_d = in_clean << (8 * n_now);
                res_cnt_d  = CNT_W'(res_n);
                err_d      = (k_now < n_now);
                if (!bus.last_in)  state_d = ST_BODY;
                else if (res_n != 0) state_d = ST_FLUSH;
                else               state_d = ST_IDLE;
            end
            ST_BODY: if (accept) begin
                out_vld_d  = 1'b1;
                out_data_d = ra_data;
                out_keep_d = ra_keep;
                res_data_d = ra_res_data;
                res_cnt_d  = ra_res_cnt;
                // A short join (s < W) always leaves res_cnt = 0, so this
                // covers both the exact-fit and the partial last beat.
                out_last_d = bus.last_in && (ra_res_cnt == '0);
                if (bus.last_in)
                    state_d = (ra_res_cnt != '0) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: if (out_free) begin
                out_vld_d  = 1'b1;
                out_data_d = res_data_q;
                out_keep_d = flush_keep;
                out_last_d = 1'b1;
                res_data_d = '0;
                res_cnt_d  = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hdr_vld_q  <= 1'b0;
            hdr_data_q <= '0;
            hdr_keep_q <= '0;
            res_data_q <= '0;
            res_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_vld_q  <= hdr_vld_d;
            hdr_data_q <= hdr_data_d;
            hdr_keep_q <= hdr_keep_d;
            res_data_q <= res_data_d;
            res_cnt_q  <= res_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
        end
    end

    assign bus.ready_in     = ready_in;
    assign bus.valid_out    = out_vld_q;
    assign bus.data_out     = out_data_q;
    assign bus.keep_out     = out_keep_q;
    assign bus.last_out     = out_last_q;
    assign bus.valid_header = hdr_vld_q;
    assign bus.data_header  = hdr_data_q;
    assign bus.keep_header  = hdr_keep_q;
    assign bus.err_short    = err_q;
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Directed bench for axi_stream_extract_header at W = 4 bytes.
// Handshaked header/payload beats are logged at the falling edge and
// compared in order against hand-computed values.
module tb_axi_stream_extract_header;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_stream_extract_header_if #(.DATA_WD(32)) bus ();

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [35:0] hdr_q[$];
    logic [36:0] pay_q[$];

    // Inputs change only just after the rising edge, so at the falling edge
    // valid & ready predicts the handshake at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.valid_header && bus.ready_header)
            hdr_q.push_back({bus.data_header, bus.keep_header});
        if (rst_n && bus.valid_out && bus.ready_out)
            pay_q.push_back({bus.data_out, bus.keep_out, bus.last_out});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_hdr(input string tag, input logic [31:0] d, input logic [3:0] k);
        logic [35:0] e;
        chk({tag, "_present"}, 64'(hdr_q.size() != 0), 64'd1);
        if (hdr_q.size() != 0) begin
            e = hdr_q.pop_front();
            chk(tag, 64'(e), 64'({d, k}));
        end
    endtask

    task automatic exp_pay(input string tag, input logic [31:0] d, input logic [3:0] k,
                           input logic l);
        logic [36:0] e;
        chk({tag, "_present"}, 64'(pay_q.size() != 0), 64'd1);
        if (pay_q.size() != 0) begin
            e = pay_q.pop_front();
            chk(tag, 64'(e), 64'({d, k, l}));
        end
    endtask

    // Offer one beat; returns just after the accepting rising edge.
    // waited = number of edges the beat was held off.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                        output int waited);
        logic done;
        done   = 1'b0;
        waited = 0;
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.keep_in  = k;
        bus.last_in  = l;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            done = bus.ready_in;
            @(posedge clk);
            #1;
            if (done) break;
            waited++;
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
        chk("accept_within_bound", 64'(done), 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n                = 1'b0;
        bus.valid_in         = 1'b0;
        bus.data_in          = '0;
        bus.keep_in          = '0;
        bus.last_in          = 1'b0;
        bus.ready_out        = 1'b1;
        bus.ready_header     = 1'b1;
        bus.byte_extract_cnt = 3'd2;
        idle_cycles(3);

        // Reset state
        chk("rst_valid_out",    64'(bus.valid_out),    64'd0);
        chk("rst_valid_header", 64'(bus.valid_header), 64'd0);
        chk("rst_err_short",    64'(bus.err_short),    64'd0);
        chk("rst_last_out",     64'(bus.last_out),     64'd0);
        chk("rst_data_out",     64'(bus.data_out),     64'd0);
        chk("rst_keep_header",  64'(bus.keep_header),  64'd0);
        chk("rst_ready_in",     64'(bus.ready_in),     64'd1);
        rst_n = 1'b1;

        // 1: N=2, residual spills into a flush beat
        bus.byte_extract_cnt = 3'd2;
        send(32'hAABBCCDD, 4'b1111, 1'b0, w);
        chk("t1_hdr_valid_lat", 64'(bus.valid_header), 64'd1);
        chk("t1_hdr_data_lat",  64'(bus.data_header),  64'hAABB0000);
        send(32'h11223344, 4'b1111, 1'b1, w);
        chk("t1_pay_valid_lat", 64'(bus.valid_out), 64'd1);
        chk("t1_pay_last_lat",  64'(bus.last_out),  64'd0);
        idle_cycles(3);
        exp_hdr("t1_hdr", 32'hAABB0000, 4'b1100);
        exp_pay("t1_p0", 32'hCCDD1122, 4'b1111, 1'b0);
        exp_pay("t1_p1", 32'h33440000, 4'b1100, 1'b1);
        chk("t1_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        // 2: N=4, exact fit, no flush
        bus.byte_extract_cnt = 3'd4;
        send(32'hDEADBEEF, 4'b1111, 1'b0, w);
        send(32'h01020304, 4'b1111, 1'b1, w);
        chk("t2_last_lat", 64'(bus.last_out), 64'd1);
        idle_cycles(3);
        exp_hdr("t2_hdr", 32'hDEADBEEF, 4'b1111);
        exp_pay("t2_p0", 32'h01020304, 4'b1111, 1'b1);
        chk("t2_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        // 3: N=1, partial last beat
        bus.byte_extract_cnt = 3'd1;
        send(32'hA1B2C3D4, 4'b1111, 1'b0, w);
        send(32'hE5F60000, 4'b1100, 1'b1, w);
        idle_cycles(3);
        exp_hdr("t3_hdr", 32'hA1000000, 4'b1000);
        exp_pay("t3_p0", 32'hB2C3D4E5, 4'b1111, 1'b0);
        exp_pay("t3_p1", 32'hF6000000, 4'b1000, 1'b1);
        chk("t3_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        // 4: header-only packet with stalled header port. N=0 clamps to 4.
        bus.ready_header     = 1'b0;
        bus.byte_extract_cnt = 3'd0;
        send(32'h01020304, 4'b1111, 1'b1, w);
        chk("t4_hdr_valid", 64'(bus.valid_header), 64'd1);
        bus.byte_extract_cnt = 3'd2;
        bus.valid_in = 1'b1;
        bus.data_in  = 32'h55667788;
        bus.keep_in  = 4'b1111;
        bus.last_in  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_ready_in_blocked", 64'(bus.ready_in),    64'd0);
            chk("t4_hdr_held",         64'(bus.data_header), 64'h01020304);
            @(posedge clk);
            #1;
        end
        bus.ready_header = 1'b1;
        send(32'h55667788, 4'b1111, 1'b1, w);
        chk("t4_accept_after_hdr_hs", 64'(w), 64'd1);
        idle_cycles(3);
        exp_hdr("t4_hdr0", 32'h01020304, 4'b1111);
        exp_hdr("t4_hdr1", 32'h55660000, 4'b1100);
        exp_pay("t4_p0", 32'h77880000, 4'b1100, 1'b1);
        chk("t4_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        // 5: N=2 body with ready_out low for 5 cycles
        bus.byte_extract_cnt = 3'd2;
        send(32'h00010203, 4'b1111, 1'b0, w);
        bus.ready_out = 1'b0;
        send(32'h04050607, 4'b1111, 1'b0, w);
        fork
            begin
                int w5;
                send(32'h08090A0B, 4'b1111, 1'b0, w5);
                chk("t5_stall_edges", 64'(w5), 64'd5);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t5_ready_in_low", 64'(bus.ready_in),  64'd0);
                    chk("t5_data_stable",  64'(bus.data_out),  64'h02030405);
                    chk("t5_valid_held",   64'(bus.valid_out), 64'd1);
                end
                @(posedge clk);
                #1;
                bus.ready_out = 1'b1;
            end
        join
        send(32'h0C0D0E0F, 4'b1111, 1'b1, w);
        idle_cycles(3);
        exp_hdr("t5_hdr", 32'h00010000, 4'b1100);
        exp_pay("t5_p0", 32'h02030405, 4'b1111, 1'b0);
        exp_pay("t5_p1", 32'h06070809, 4'b1111, 1'b0);
        exp_pay("t5_p2", 32'h0A0B0C0D, 4'b1111, 1'b0);
        exp_pay("t5_p3", 32'h0E0F0000, 4'b1100, 1'b1);
        chk("t5_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        // 6: short first beat, then reset mid-BODY, then a clean packet
        bus.byte_extract_cnt = 3'd3;
        send(32'hC0C1C2C3, 4'b1100, 1'b0, w);
        chk("t6_err_pulse",   64'(bus.err_short),   64'd1);
        chk("t6_keep_header", 64'(bus.keep_header), 64'b1100);
        chk("t6_data_header", 64'(bus.data_header), 64'hC0C10000);
        idle_cycles(1);
        chk("t6_err_one_cycle", 64'(bus.err_short), 64'd0);
        send(32'hD0D1D2D3, 4'b1111, 1'b0, w);
        chk("t6_body_out", 64'(bus.data_out), 64'hD0D1D2D3);
        idle_cycles(1);
        rst_n = 1'b0;
        idle_cycles(1);
        chk("t6_rst_valid_out",    64'(bus.valid_out),    64'd0);
        chk("t6_rst_valid_header", 64'(bus.valid_header), 64'd0);
        chk("t6_rst_ready_in",     64'(bus.ready_in),     64'd1);
        rst_n = 1'b1;
        exp_hdr("t6_hdr0", 32'hC0C10000, 4'b1100);
        exp_pay("t6_p0", 32'hD0D1D2D3, 4'b1111, 1'b0);
        bus.byte_extract_cnt = 3'd2;
        send(32'h12345678, 4'b1111, 1'b0, w);
        send(32'h9ABCDEF0, 4'b1000, 1'b1, w);
        chk("t6_short_join_data", 64'(bus.data_out), 64'h56789A00);
        chk("t6_short_join_keep", 64'(bus.keep_out), 64'b1110);
        idle_cycles(3);
        exp_hdr("t6_hdr1", 32'h12340000, 4'b1100);
        exp_pay("t6_p1", 32'h56789A00, 4'b1110, 1'b1);
        chk("t6_no_extra", 64'(pay_q.size() + hdr_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
